// File: rtl/mu2cgra_stream_buffer.sv
// Purpose: elastic FIFO between the matrix-unit systolic-array output and the CGRA tile array.
// Latency: 1 cycle from an accepted push into an empty buffer to out_vld; no same-cycle pass-through.
// Backpressure: in_rdy drops when DEPTH beats are stored; out_dat holds at the head while out_rdy is low.
// Optional: define MU2CGRA_BUF_STATS_EN to add the 32-bit saturating stall_cnt output.
module mu2cgra_stream_buffer #(
    parameter int DEPTH = 4,
    parameter int DAT_W = 512
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [DAT_W-1:0]         in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DAT_W-1:0]         out_dat,
    input  logic                     flush,
`ifdef MU2CGRA_BUF_STATS_EN
    output logic [31:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);

    // Pointers carry one extra bit so full (MSBs differ) and empty (equal) are distinguishable.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_alive;
    logic [DAT_W-1:0] r_mem [DEPTH];

    logic [AW:0]      w_occ;
    logic             w_push;
    logic             w_pop;

    // Status is decoded only from registered state, so no input can reach in_rdy/out_vld combinationally.
    // r_alive keeps in_rdy low during reset and releases it on the first edge afterwards.
    assign w_occ     = r_wptr - r_rptr;
    assign occupancy = w_occ;
    assign in_rdy    = r_alive && (w_occ != L_DEPTH);
    assign out_vld   = (w_occ != '0);
    assign out_dat   = r_mem[r_rptr[AW-1:0]];

    // A flush cycle discards any handshake that coincides with it.
    assign w_push = in_vld && in_rdy && !flush;
    assign w_pop  = out_vld && out_rdy && !flush;

    // Pointer and ready-enable state; flush rewinds both pointers to zero.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + L_ONE;
                if (w_pop)  r_rptr <= r_rptr + L_ONE;
            end
        end
    end

    // Beat storage is left unreset; the lower pointer bits index it, so wrap is modulo DEPTH.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_dat;
    end

`ifdef MU2CGRA_BUF_STATS_EN
    logic [31:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;

    // Count cycles the CGRA stalls a presented beat; saturates, cleared by flush.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (out_vld && !out_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mu2cgra_stream_buffer.sv
// Purpose: directed self-checking bench for mu2cgra_stream_buffer (DEPTH=4, DAT_W=512).
// Latency: inputs change 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: out_rdy is driven directly to exercise full, stall and drain cases.
module tb_mu2cgra_stream_buffer;

    localparam int DEPTH = 4;
    localparam int DAT_W = 512;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic             in_vld;
    logic             in_rdy;
    logic [DAT_W-1:0] in_dat;
    logic             out_vld;
    logic             out_rdy;
    logic [DAT_W-1:0] out_dat;
    logic             flush;
    logic [2:0]       occupancy;
`ifdef MU2CGRA_BUF_STATS_EN
    logic [31:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mu2cgra_stream_buffer #(.DEPTH(DEPTH), .DAT_W(DAT_W)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_dat    (in_dat),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_dat   (out_dat),
        .flush     (flush),
`ifdef MU2CGRA_BUF_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    task automatic check_val(input string tag, input logic [DAT_W-1:0] obs, input logic [DAT_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every lane carries the same 16-bit tag so lane corruption would show.
    function automatic logic [DAT_W-1:0] beat(input logic [15:0] k);
        return {32{k}};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic iv, input logic ov, input logic [2:0] occ);
        check_val({tag, "_in_rdy"},  DAT_W'(in_rdy),    DAT_W'(iv));
        check_val({tag, "_out_vld"}, DAT_W'(out_vld),   DAT_W'(ov));
        check_val({tag, "_occ"},     DAT_W'(occupancy), DAT_W'(occ));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in = 1'b0;
        in_vld   = 1'b0;
        in_dat   = '0;
        out_rdy  = 1'b0;
        flush    = 1'b0;
        #3;
        chk_state("reset", 1'b0, 1'b0, 3'd0);
        step();
        step();
        #3 reset_in = 1'b1;
        step();
        chk_state("release", 1'b1, 1'b0, 3'd0);

        // Single beat through an empty buffer with the sink ready.
        in_vld  = 1'b1;
        in_dat  = 512'h1;
        out_rdy = 1'b1;
        #1;
        check_val("no_comb_path", DAT_W'(out_vld), '0);
        step();
        in_vld = 1'b0;
        chk_state("single_push", 1'b1, 1'b1, 3'd1);
        check_val("single_dat", out_dat, 512'h1);
        step();
        chk_state("single_pop", 1'b1, 1'b0, 3'd0);

        // Fill to full with sink stalled, offer a fifth beat, then drain.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_dat = beat(16'(k));
            step();
        end
        chk_state("full", 1'b0, 1'b1, 3'd4);
        in_dat = beat(16'd5);
        step();
        chk_state("full_hold", 1'b0, 1'b1, 3'd4);
        check_val("full_head", out_dat, beat(16'd1));
        out_rdy = 1'b1;
        #1;
        check_val("full_no_passthru", DAT_W'(in_rdy), '0);
        step();
        chk_state("drain1", 1'b1, 1'b1, 3'd3);
        check_val("drain1_dat", out_dat, beat(16'd2));
        step();
        in_vld = 1'b0;
        check_val("drain2_occ", DAT_W'(occupancy), DAT_W'(3'd3));
        check_val("drain2_dat", out_dat, beat(16'd3));
        step();
        check_val("drain3_dat", out_dat, beat(16'd4));
        step();
        check_val("drain4_dat", out_dat, beat(16'd5));
        step();
        chk_state("drained", 1'b1, 1'b0, 3'd0);

        // Steady push+pop at occupancy 2 for 10 cycles; pointers wrap.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_dat  = beat(16'h10);
        step();
        in_dat  = beat(16'h11);
        step();
        check_val("steady_pre_occ", DAT_W'(occupancy), DAT_W'(3'd2));
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_dat = beat(16'(16'h12 + i));
            step();
            check_val("steady_occ", DAT_W'(occupancy), DAT_W'(3'd2));
            check_val("steady_dat", out_dat, beat(16'(16'h11 + i)));
        end
        in_vld = 1'b0;
        step();
        check_val("steady_tail_dat", out_dat, beat(16'h1B));
        step();
        chk_state("steady_empty", 1'b1, 1'b0, 3'd0);

        // Flush at occupancy 3 together with an offered beat.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_dat = beat(16'(16'h20 + k));
            step();
        end
        check_val("pre_flush_occ", DAT_W'(occupancy), DAT_W'(3'd3));
        flush   = 1'b1;
        out_rdy = 1'b1;
        in_dat  = beat(16'h23);
        step();
        flush  = 1'b0;
        in_vld = 1'b0;
        chk_state("flush", 1'b1, 1'b0, 3'd0);
        step();
        chk_state("flush_hold", 1'b1, 1'b0, 3'd0);
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_dat  = beat(16'h24);
        step();
        in_vld = 1'b0;
        check_val("post_flush_dat", out_dat, beat(16'h24));
        check_val("post_flush_occ", DAT_W'(occupancy), DAT_W'(3'd1));
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        check_val("post_flush_empty", DAT_W'(occupancy), '0);

`ifdef MU2CGRA_BUF_STATS_EN
        // Seven stalled cycles with a beat presented, then flush clears the count.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("stall_clr0", DAT_W'(stall_cnt), '0);
        in_vld = 1'b1;
        in_dat = beat(16'h30);
        step();
        in_vld = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check_val("stall_7", DAT_W'(stall_cnt), DAT_W'(32'd7));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("stall_flush", DAT_W'(stall_cnt), '0);
        check_val("stall_flush_occ", DAT_W'(occupancy), '0);
`endif

        // Asynchronous reset mid-burst at occupancy 2.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_dat  = beat(16'h40);
        step();
        in_dat  = beat(16'h41);
        step();
        check_val("pre_rst_occ", DAT_W'(occupancy), DAT_W'(3'd2));
        #2 reset_in = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 1'b0, 3'd0);
        in_vld = 1'b0;
        step();
        #3 reset_in = 1'b1;
        step();
        chk_state("rst_release", 1'b1, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mu2cgra_stream_buffer.md
MU2CGRA_STREAM_BUFFER -- requirements
Module: mu2cgra_stream_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter DAT_W, default 512, beat width (32 lanes x 16 bit, lane i = bits [16i+15:16i]).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_in, input, 1 bit: the block clock.
REQ-005 SHALL have port reset_in, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_vld, input, 1 bit: the matrix unit systolic-array output beat is valid.
REQ-007 SHALL have port in_rdy, output, 1 bit: the buffer accepts a beat.
REQ-008 SHALL have port in_dat, input, DAT_W bits: the systolic-array output beat.
REQ-009 SHALL have port out_vld, output, 1 bit: a beat is presented to the CGRA tile array.
REQ-010 SHALL have port out_rdy, input, 1 bit: the CGRA accepts the beat.
REQ-011 SHALL have port out_dat, output, DAT_W bits: the beat presented to the CGRA.
REQ-012 SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-013 SHALL have port occupancy, output, clog2(DEPTH)+1 bits: the number of stored beats.

Function
REQ-014 SHALL push in_dat on a rising clk_in edge when in_vld and in_rdy are both high.
REQ-015 SHALL pop the head entry on a rising clk_in edge when out_vld and out_rdy are both high.
REQ-016 SHALL drive in_rdy = (occupancy != DEPTH) and out_vld = (occupancy != 0), decoded from registered state only.
REQ-017 SHALL have no combinational path from in_* to out_*; a push into an empty buffer raises out_vld exactly 1 cycle later.
REQ-018 SHALL present out_dat from the head entry and hold it stable while out_vld is high and out_rdy is low.
REQ-019 SHALL, on a simultaneous push and pop, leave occupancy unchanged, advance both pointers, and preserve order.
REQ-020 SHALL, when full, keep in_rdy low even if out_rdy is high that cycle; no same-cycle pass-through.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; the extra pointer bit distinguishes full from empty.
REQ-022 SHALL, on flush, reset pointers and occupancy to 0 at the next edge, ignoring any push or pop that cycle.
REQ-023 SHALL, on flush, hold out_vld low from the following cycle until a new push is accepted.
REQ-024 SHALL treat in_dat as opaque; no lane reordering or arithmetic is performed.

Reset
REQ-025 SHALL, while reset_in is low, asynchronously force pointers and occupancy to 0, in_rdy to 0, and out_vld to 0.
REQ-026 SHALL drive in_rdy high on the first clk_in edge after reset_in deasserts.
REQ-027 SHALL leave storage array contents unreset; out_dat is don't-care while out_vld is low.
REQ-028 SHALL, on reset asserted mid-transfer, lose all stored beats with no partial beat visible afterwards.

Configuration
REQ-029 SHALL support macro MU2CGRA_BUF_STATS_EN; when defined, it adds output stall_cnt (32 bits).
REQ-030 SHALL, with MU2CGRA_BUF_STATS_EN defined, increment stall_cnt each cycle out_vld=1 and out_rdy=0.
REQ-031 SHALL, with MU2CGRA_BUF_STATS_EN defined, saturate stall_cnt at 0xFFFFFFFF, clear it on flush, and reset it to 0.
REQ-032 SHALL, with MU2CGRA_BUF_STATS_EN undefined, omit the stall_cnt port and all related logic, leaving FIFO behaviour identical.

Verification
REQ-033 SHALL cover: reset release, then one push 0x...0001 with out_rdy=1 -> out_vld high 1 cycle after the push, out_dat=0x...0001, occupancy back to 0.
REQ-034 SHALL cover: DEPTH=4, out_rdy=0, 5 beats offered -> 4 accepted, in_rdy=0 from the 4th accept onward, occupancy=4; after out_rdy=1, beats drain in order 1,2,3,4 and the 5th is then accepted.
REQ-035 SHALL cover: occupancy=2 with continuous push and pop for 10 cycles -> occupancy stays 2, output order matches input order, and pointers wrap twice.
REQ-036 SHALL cover: occupancy=3 with flush and in_vld asserted together -> next cycle occupancy=0, out_vld=0, and the offered beat is dropped.
REQ-037 SHALL cover: reset_in pulled low mid-burst at occupancy=2 -> out_vld and in_rdy drop immediately with no clock edge; after release, occupancy=0.
REQ-038 SHALL cover: with MU2CGRA_BUF_STATS_EN defined, out_vld=1 and out_rdy=0 for 7 cycles -> stall_cnt=7; flush -> stall_cnt=0.
